// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader: the loader FSM state encoding
// and the byte order of the loader stream.
// No ports (package).
// ---------------------------------------------------------------------------
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      COUNT = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
      CHECK = 3'd5,
      DONE  = 3'd6,
      ERROR = 3'd7
   } loaderState_e;

   // Stream words arrive most significant byte first.
   localparam bit STREAM_MSB_FIRST = 1'b1;
   localparam int BYTES_PER_WORD   = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// loader_word_assembler
// Collects stream bytes into a 32-bit word using a 4-byte shift register and
// a byte counter.
// Ports:
//   clk          system clock
//   rstN         synchronous active-low reset
//   clear        drop any partial word and restart the byte count
//   shiftEn      a byte is accepted this cycle
//   byteIn       stream byte
//   nextWord     shift register contents including the current byteIn
//   wordComplete the byte accepted this cycle completes a word
// ---------------------------------------------------------------------------
module loader_word_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstN,
   input  logic        clear,
   input  logic        shiftEn,
   input  logic [7:0]  byteIn,
   output logic [31:0] nextWord,
   output logic        wordComplete
);

   logic [31:0] shiftReg;
   logic [1:0]  byteCnt;

   always_comb begin
      if (STREAM_MSB_FIRST) nextWord = {shiftReg[23:0], byteIn};
      else                  nextWord = {byteIn, shiftReg[31:8]};
   end

   // Combinational so the FSM can leave DATA on the same edge that takes
   // the last byte of the word.
   assign wordComplete = shiftEn && (byteCnt == 2'(BYTES_PER_WORD - 1));

   // The 2-bit counter wraps to 0 after the 4th byte, ready for the next word.
   always_ff @(posedge clk) begin
      if (!rstN || clear) begin
         shiftReg <= '0;
         byteCnt  <= '0;
      end else if (shiftEn) begin
         shiftReg <= nextWord;
         byteCnt  <= byteCnt + 2'd1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Receives a program over a byte stream (word count, then words MSB first)
// and writes it into instruction memory, then raises start.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailer byte that must
// equal the XOR of the count byte and all data bytes.
// Parameters:
//   MAX_WORDS      instruction memory depth in 32-bit words
// Ports:
//   clk            system clock
//   rstN           synchronous active-low reset
//   loadReq        one-cycle request to start a load
//   byteIn         stream data
//   byteValid      byteIn is valid
//   byteReady      loader accepts byteIn (transfer when valid & ready)
//   resetInstMem   one-cycle instruction memory clear pulse
//   wrInstMem      instruction memory write strobe
//   writeInstAddr  byte address of the write
//   writeInstData  data of the write
//   start          a program is loaded
//   busy           a load is in progress
//   loadErr        the last load failed
// ---------------------------------------------------------------------------
module program_loader
   import program_loader_pkg::*;
#(
   parameter int MAX_WORDS = 11
)
(
   input  logic        clk,
   input  logic        rstN,
   input  logic        loadReq,
   input  logic [7:0]  byteIn,
   input  logic        byteValid,
   output logic        byteReady,
   output logic        resetInstMem,
   output logic        wrInstMem,
   output logic [31:0] writeInstAddr,
   output logic [31:0] writeInstData,
   output logic        start,
   output logic        busy,
   output logic        loadErr
);

   loaderState_e state;
   logic [7:0]   idx;
   logic [7:0]   wordCount;
   logic [7:0]   idxNext;
   logic [8:0]   maxN;
   logic         accept;
   logic         wordComplete;
   logic [31:0]  nextWord;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]   checksum;
`endif

   assign accept  = byteValid && byteReady;
   assign idxNext = idx + 8'd1;
   assign maxN    = 9'(MAX_WORDS);

   loader_word_assembler uAssembler (
      .clk          (clk),
      .rstN         (rstN),
      .clear        (state == CLEAR),
      .shiftEn      (accept && (state == DATA)),
      .byteIn       (byteIn),
      .nextWord     (nextWord),
      .wordComplete (wordComplete)
   );

   // All outputs are registered and updated on the edge that enters the
   // state they belong to.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state         <= IDLE;
         idx           <= '0;
         wordCount     <= '0;
         byteReady     <= 1'b0;
         resetInstMem  <= 1'b0;
         wrInstMem     <= 1'b0;
         writeInstAddr <= '0;
         writeInstData <= '0;
         start         <= 1'b0;
         busy          <= 1'b0;
         loadErr       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum      <= '0;
`endif
      end else begin
         resetInstMem <= 1'b0;
         wrInstMem    <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (loadReq) begin
                  state        <= CLEAR;
                  resetInstMem <= 1'b1;
                  start        <= 1'b0;
                  loadErr      <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            CLEAR: begin
               state     <= COUNT;
               byteReady <= 1'b1;
               idx       <= '0;
            end
            COUNT: begin
               if (accept) begin
                  wordCount <= byteIn;
`ifdef LOADER_CHECKSUM_EN
                  checksum  <= byteIn;
`endif
                  if (byteIn == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state     <= CHECK;
`else
                     state     <= DONE;
                     byteReady <= 1'b0;
                     busy      <= 1'b0;
                     start     <= 1'b1;
`endif
                  end else if ({1'b0, byteIn} > maxN) begin
                     state     <= ERROR;
                     byteReady <= 1'b0;
                     busy      <= 1'b0;
                     loadErr   <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                  checksum <= checksum ^ byteIn;
`endif
                  if (wordComplete) begin
                     state         <= WRITE;
                     byteReady     <= 1'b0;
                     wrInstMem     <= 1'b1;
                     writeInstAddr <= {22'd0, idx, 2'b00};
                     writeInstData <= nextWord;
                  end
               end
            end
            WRITE: begin
               idx <= idxNext;
               if (idxNext < wordCount) begin
                  state     <= DATA;
                  byteReady <= 1'b1;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  state     <= CHECK;
                  byteReady <= 1'b1;
`else
                  state     <= DONE;
                  busy      <= 1'b0;
                  start     <= 1'b1;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (accept) begin
                  byteReady <= 1'b0;
                  busy      <= 1'b0;
                  if (byteIn == checksum) begin
                     state <= DONE;
                     start <= 1'b1;
                  end else begin
                     state   <= ERROR;
                     loadErr <= 1'b1;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   localparam int MAX_WORDS = 11;

   logic        clk = 1'b0;
   logic        rstN;
   logic        loadReq;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        byteReady;
   logic        resetInstMem;
   logic        wrInstMem;
   logic [31:0] writeInstAddr;
   logic [31:0] writeInstData;
   logic        start;
   logic        busy;
   logic        loadErr;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t expWrites[$];
   wr_t monWr;
   int  nCompared = 0;
   int  nMismatch = 0;
   logic prevWr = 1'b0;

   program_loader #(.MAX_WORDS(MAX_WORDS)) dut (
      .clk           (clk),
      .rstN          (rstN),
      .loadReq       (loadReq),
      .byteIn        (byteIn),
      .byteValid     (byteValid),
      .byteReady     (byteReady),
      .resetInstMem  (resetInstMem),
      .wrInstMem     (wrInstMem),
      .writeInstAddr (writeInstAddr),
      .writeInstData (writeInstData),
      .start         (start),
      .busy          (busy),
      .loadErr       (loadErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (wrInstMem) begin
         check("wrPulseWidth", 32'(prevWr), 32'd0);
         if (expWrites.size() == 0) begin
            check("unexpectedWrite", 32'(wrInstMem), 32'd0);
         end else begin
            monWr = expWrites.pop_front();
            check("wrAddr", writeInstAddr, monWr.addr);
            check("wrData", writeInstData, monWr.data);
         end
      end
      prevWr = wrInstMem;
   end

   // Offer one byte, optionally after idle cycles; returns on the negedge
   // following the transfer.
   task automatic sendByte(input logic [7:0] b, input int gapMode);
      int idle;
      int t;
      idle = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idle) @(negedge clk);
      byteIn    = b;
      byteValid = 1'b1;
      t = 0;
      while (!byteReady && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("byteAccepted", 32'(byteReady), 32'd1);
      @(negedge clk);
      byteValid = 1'b0;
   endtask

   task automatic pulseLoad();
      loadReq = 1'b1;
      @(negedge clk);
      loadReq = 1'b0;
      check("clearPulse", 32'(resetInstMem), 32'd1);
      check("clearBusy", 32'(busy), 32'd1);
      check("clearStartErr", 32'({start, loadErr}), 32'd0);
      @(negedge clk);
      check("clearOnce", 32'(resetInstMem), 32'd0);
   endtask

   // One complete load of n random words; the reference model is the list of
   // words itself, the addresses i*4, and the XOR of every streamed byte.
   task automatic runLoad(input int n, input int gapMode, input bit badTrailer,
                          input logic [31:0] w0, input logic [31:0] w1, input bit useGiven);
      logic [31:0] words[$];
      logic [31:0] w;
      logic [7:0]  sum;
      bit          expErr;
      int          t;
      expErr = (n > MAX_WORDS);
      sum    = 8'(n);
      if (!expErr) begin
         for (int i = 0; i < n; i++) begin
            w = useGiven ? ((i == 0) ? w0 : w1) : $urandom;
            words.push_back(w);
            expWrites.push_back('{addr: 32'(i * 4), data: w});
            sum = sum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         end
      end
      pulseLoad();
      sendByte(8'(n), gapMode);
      if (!expErr) begin
         for (int i = 0; i < n; i++)
            for (int b = 3; b >= 0; b--)
               sendByte(words[i][8*b +: 8], gapMode);
`ifdef LOADER_CHECKSUM_EN
         sendByte(badTrailer ? (sum ^ 8'h5A) : sum, gapMode);
         expErr = badTrailer;
`endif
      end
      t = 0;
      while (busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("loadFinished", 32'(busy), 32'd0);
      if (n == 0) check("zeroStartLatency", 32'(t <= 2), 32'd1);
      check("startOut", 32'(start), 32'(!expErr));
      check("loadErrOut", 32'(loadErr), 32'(expErr));
      check("readyWhenIdle", 32'(byteReady), 32'd0);
      check("allWritesSeen", 32'(expWrites.size()), 32'd0);
      if (n > 0 && n <= MAX_WORDS) begin
         check("holdAddr", writeInstAddr, 32'((n - 1) * 4));
         check("holdData", writeInstData, words[n-1]);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rstN      = 1'b0;
      loadReq   = 1'b0;
      byteIn    = 8'h00;
      byteValid = 1'b0;
      repeat (3) @(negedge clk);
      check("resetCtrl", 32'({byteReady, resetInstMem, wrInstMem, start, busy, loadErr}), 32'd0);
      check("resetAddr", writeInstAddr, 32'd0);
      check("resetData", writeInstData, 32'd0);
      rstN = 1'b1;
      @(negedge clk);

      // Directed: two-word program.
      runLoad(2, 0, 1'b0, 32'h01020304, 32'hAABBCCDD, 1'b1);
      // Empty program.
      runLoad(0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      // Oversized program is rejected.
      runLoad(12, 0, 1'b0, 32'h0, 32'h0, 1'b0);
      // byteValid toggling every other cycle.
      runLoad(1, 1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1);
      // Full-depth program.
      runLoad(MAX_WORDS, 0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Reset in the middle of word 0; reset also wins over loadReq.
      pulseLoad();
      sendByte(8'd2, 0);
      sendByte(8'h11, 0);
      sendByte(8'h22, 0);
      rstN    = 1'b0;
      loadReq = 1'b1;
      @(negedge clk);
      check("midResetCtrl", 32'({byteReady, resetInstMem, wrInstMem, start, busy, loadErr}), 32'd0);
      check("midResetAddr", writeInstAddr, 32'd0);
      check("midResetData", writeInstData, 32'd0);
      loadReq = 1'b0;
      rstN    = 1'b1;
      repeat (3) @(negedge clk);
      check("idleAfterReset", 32'(busy), 32'd0);
      runLoad(1, 0, 1'b0, 32'h55667788, 32'h0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
      runLoad(2, 0, 1'b1, 32'h0, 32'h0, 1'b0);
      runLoad(2, 0, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

      for (int k = 0; k < 10; k++) begin
`ifdef LOADER_CHECKSUM_EN
         runLoad(int'($urandom_range(0, MAX_WORDS + 2)), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) == 0), 32'h0, 32'h0, 1'b0);
`else
         runLoad(int'($urandom_range(0, MAX_WORDS + 2)), int'($urandom_range(0, 2)),
                 1'b0, 32'h0, 32'h0, 1'b0);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", nCompared);
      $fatal(1, "watchdog");
   end

endmodule
